// File: rtl/ras_pkg.sv
// Shared sizing constants and the checkpoint record for the return-address stack predictor.
package ras_pkg;

  // Checkpoint fields are sized for the largest supported stack so one record type serves every instance.
  localparam int unsigned XLEN_MAX       = 64;
  localparam int unsigned RAS_DEPTH_MAX  = 64;
  localparam int unsigned CKPT_DEPTH_DEF = 8;

  localparam int unsigned RAS_PTR_W  = $clog2(RAS_DEPTH_MAX);
  localparam int unsigned RAS_CNT_W  = $clog2(RAS_DEPTH_MAX + 1);
  localparam int unsigned CKPT_PTR_W = $clog2(CKPT_DEPTH_DEF);

  typedef struct packed {
    logic [RAS_PTR_W-1:0] tos;
    logic [RAS_CNT_W-1:0] count;
    logic                 wr_en;
    logic [RAS_PTR_W-1:0] wr_slot;
    logic [XLEN_MAX-1:0]  old_data;
  } ras_ckpt_t;

endpackage

// File: rtl/ras_ckpt_fifo.sv
// In-order queue of RAS checkpoints; exposes the two oldest entries for commit/flush repair.
module ras_ckpt_fifo
  import ras_pkg::*;
#(
  parameter int unsigned DEPTH = CKPT_DEPTH_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  ras_ckpt_t                  wr_data,
  output ras_ckpt_t                  oldest_c,
  output ras_ckpt_t                  second_c,
  output logic [$clog2(DEPTH+1)-1:0] occ,
  output logic                       full_c,
  output logic                       empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  ras_ckpt_t        mem_q [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [OCC_W-1:0] occ_q;

  assign oldest_c = mem_q[head_q];
  assign second_c = mem_q[head_q + PTR_W'(1)];
  assign occ      = occ_q;
  assign full_c   = (occ_q == OCC_W'(DEPTH));
  assign empty_c  = (occ_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else if (clear) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      if (push) tail_q <= tail_q + PTR_W'(1);
      if (pop)  head_q <= head_q + PTR_W'(1);
      if (push && !pop)      occ_q <= occ_q + OCC_W'(1);
      else if (pop && !push) occ_q <= occ_q - OCC_W'(1);
    end
  end

  // Payload storage needs no reset: entries are only read while occupied.
  always_ff @(posedge clk_i) begin
    if (push && !clear) mem_q[tail_q] <= wr_data;
  end

endmodule

// File: rtl/ras_ckpt_predictor.sv
// Return-address stack with one checkpoint per in-flight op, repaired from the oldest live checkpoint on flush.
module ras_ckpt_predictor
  import ras_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RAS_DEPTH  = 16,
  parameter int unsigned CKPT_DEPTH = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           stall_i,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  logic [XLEN-1:0]                push_addr_i,
  input  logic                           commit_i,
  input  logic                           flush_i,
  output logic                           pred_valid_o,
  output logic [XLEN-1:0]                pred_addr_o,
  output logic                           ckpt_full_o,
  output logic [$clog2(RAS_DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int unsigned OCC_W = $clog2(CKPT_DEPTH + 1);

  if (RAS_DEPTH > RAS_DEPTH_MAX || XLEN > XLEN_MAX || RAS_DEPTH < 2 || CKPT_DEPTH < 2 ||
      (RAS_DEPTH & (RAS_DEPTH - 1)) != 0 || (CKPT_DEPTH & (CKPT_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("ras_ckpt_predictor: unsupported RAS_DEPTH/CKPT_DEPTH/XLEN");
  end

  logic [XLEN-1:0]  stack_q [RAS_DEPTH];
  logic [PTR_W-1:0] tos_q, tos_d, tos_m1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             st_we;
  logic [PTR_W-1:0] st_idx;
  logic [XLEN-1:0]  st_wdata;

  ras_ckpt_t        ck_new, ck_oldest, ck_second, ck_rst;
  logic [OCC_W-1:0] ck_occ;
  logic             ck_full, ck_empty, ck_rst_vld;
  logic             op_acc, op_do, do_commit;

  assign tos_m1       = tos_q - PTR_W'(1);
  assign pred_addr_o  = stack_q[tos_m1];
  assign pred_valid_o = (cnt_q != '0);
  assign count_o      = cnt_q;
  assign ckpt_full_o  = ck_full;

  // A commit in the flush cycle retires the oldest op first, so repair comes from the next one.
  assign do_commit  = commit_i && !stall_i && !ck_empty;
  assign op_acc     = (push_i || pop_i) && !stall_i && !flush_i;
  assign op_do      = op_acc && (!ck_full || do_commit);
  assign ck_rst     = do_commit ? ck_second : ck_oldest;
  assign ck_rst_vld = do_commit ? (ck_occ >= OCC_W'(2)) : !ck_empty;

  always_comb begin
    tos_d    = tos_q;
    cnt_d    = cnt_q;
    st_we    = 1'b0;
    st_idx   = tos_q;
    st_wdata = push_addr_i;
    ck_new   = '0;
    ck_new.tos   = RAS_PTR_W'(tos_q);
    ck_new.count = RAS_CNT_W'(cnt_q);
    if (flush_i) begin
      if (ck_rst_vld) begin
        tos_d = PTR_W'(ck_rst.tos);
        cnt_d = CNT_W'(ck_rst.count);
        if (ck_rst.wr_en) begin
          st_we    = 1'b1;
          st_idx   = PTR_W'(ck_rst.wr_slot);
          st_wdata = XLEN'(ck_rst.old_data);
        end
      end
    end else if (op_do) begin
      if (push_i && pop_i && cnt_q != '0) begin
        st_we  = 1'b1;
        st_idx = tos_m1;
      end else if (push_i) begin
        st_we = 1'b1;
        tos_d = tos_q + PTR_W'(1);
        if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + CNT_W'(1);
      end else if (cnt_q != '0) begin
        tos_d = tos_m1;
        cnt_d = cnt_q - CNT_W'(1);
      end
      ck_new.wr_en    = st_we;
      ck_new.wr_slot  = RAS_PTR_W'(st_idx);
      ck_new.old_data = XLEN_MAX'(stack_q[st_idx]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tos_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) stack_q[i] <= '0;
    end else begin
      tos_q <= tos_d;
      cnt_q <= cnt_d;
      if (st_we) stack_q[st_idx] <= st_wdata;
    end
  end

  ras_ckpt_fifo #(.DEPTH(CKPT_DEPTH)) u_ckpt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push     (op_do),
    .pop      (do_commit),
    .clear    (flush_i),
    .wr_data  (ck_new),
    .oldest_c (ck_oldest),
    .second_c (ck_second),
    .occ      (ck_occ),
    .full_c   (ck_full),
    .empty_c  (ck_empty)
  );

  // Protocol checks on decode/execute handshakes.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(commit_i && !stall_i && ck_empty))
        else $error("ras_ckpt_predictor: commit with no outstanding checkpoint");
      assert (!(op_acc && ck_full && !do_commit))
        else $error("ras_ckpt_predictor: RAS op accepted while checkpoint queue full");
    end
  end

endmodule

// File: tb/tb_ras_ckpt_predictor.sv
// Directed bench for ras_ckpt_predictor: default instance plus a 4-deep stack sharing the same stimulus.
module tb_ras_ckpt_predictor;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        stall_i = 1'b0;
  logic        push_i = 1'b0;
  logic        pop_i = 1'b0;
  logic [31:0] push_addr_i = '0;
  logic        commit_i = 1'b0;
  logic        flush_i = 1'b0;

  logic        pred_valid, full;
  logic [31:0] pred_addr;
  logic [4:0]  count;
  logic        pred_valid4, full4;
  logic [31:0] pred_addr4;
  logic [2:0]  count4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  ras_ckpt_predictor dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall_i), .push_i(push_i), .pop_i(pop_i),
    .push_addr_i(push_addr_i), .commit_i(commit_i), .flush_i(flush_i),
    .pred_valid_o(pred_valid), .pred_addr_o(pred_addr), .ckpt_full_o(full), .count_o(count)
  );

  ras_ckpt_predictor #(.XLEN(32), .RAS_DEPTH(4), .CKPT_DEPTH(8)) dut4 (
    .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall_i), .push_i(push_i), .pop_i(pop_i),
    .push_addr_i(push_addr_i), .commit_i(commit_i), .flush_i(flush_i),
    .pred_valid_o(pred_valid4), .pred_addr_o(pred_addr4), .ckpt_full_o(full4), .count_o(count4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with the given inputs, then inputs return to idle; outputs settle 1 time unit past the edge.
  task automatic cyc(input logic ps, input logic pp, input logic [31:0] a,
                     input logic cm, input logic fl, input logic st);
    push_i = ps; pop_i = pp; push_addr_i = a; commit_i = cm; flush_i = fl; stall_i = st;
    @(posedge clk_i);
    #1;
    push_i = 1'b0; pop_i = 1'b0; push_addr_i = '0; commit_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #2;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_valid", 32'(pred_valid), 32'd0);
    check("rst_addr", pred_addr, 32'h0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_count4", 32'(count4), 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Committed pushes then pops
    cyc(1, 0, 32'h100, 0, 0, 0);
    cyc(1, 0, 32'h200, 1, 0, 0);
    cyc(1, 0, 32'h300, 1, 0, 0);
    cyc(0, 0, 32'h0, 1, 0, 0);
    check("s1_count", 32'(count), 32'd3);
    check("s1_top", pred_addr, 32'h300);
    check("s1_valid", 32'(pred_valid), 32'd1);
    cyc(0, 1, 32'h0, 0, 0, 0);
    check("s1_pop1", pred_addr, 32'h200);
    cyc(0, 1, 32'h0, 1, 0, 0);
    check("s1_pop2", pred_addr, 32'h100);
    cyc(0, 1, 32'h0, 1, 0, 0);
    check("s1_pop3_valid", 32'(pred_valid), 32'd0);
    check("s1_pop3_count", 32'(count), 32'd0);
    cyc(0, 0, 32'h0, 1, 0, 0);

    // Flush squashes an uncommitted push
    do_reset();
    cyc(1, 0, 32'h100, 0, 0, 0);
    cyc(0, 0, 32'h0, 1, 0, 0);
    cyc(1, 0, 32'h200, 0, 0, 0);
    check("s2_pre_top", pred_addr, 32'h200);
    cyc(0, 0, 32'h0, 0, 1, 0);
    check("s2_count", 32'(count), 32'd1);
    check("s2_top", pred_addr, 32'h100);
    check("s2_full", 32'(full), 32'd0);

    // Flush squashes an uncommitted pop; underflow pop keeps state
    do_reset();
    cyc(1, 0, 32'hA0, 0, 0, 0);
    cyc(0, 0, 32'h0, 1, 0, 0);
    cyc(0, 1, 32'h0, 0, 0, 0);
    check("s3_pop_valid", 32'(pred_valid), 32'd0);
    cyc(0, 0, 32'h0, 0, 1, 0);
    check("s3_count", 32'(count), 32'd1);
    check("s3_top", pred_addr, 32'hA0);
    cyc(0, 1, 32'h0, 0, 0, 0);
    check("s3_pop_valid2", 32'(pred_valid), 32'd0);
    cyc(0, 1, 32'h0, 1, 0, 0);
    check("s3_underflow_count", 32'(count), 32'd0);
    cyc(0, 0, 32'h0, 1, 0, 0);

    // 4-deep stack overflow, plus repair of an overwritten slot below the top
    do_reset();
    cyc(1, 0, 32'h10, 0, 0, 0);
    for (int i = 2; i <= 5; i++) cyc(1, 0, 32'(i * 16), 1, 0, 0);
    cyc(0, 0, 32'h0, 1, 0, 0);
    check("s4_count4", 32'(count4), 32'd4);
    check("s4_top4", pred_addr4, 32'h50);
    check("s4_count16", 32'(count), 32'd5);
    cyc(1, 0, 32'h60, 0, 0, 0);
    check("s4_push60", pred_addr4, 32'h60);
    check("s4_push60_count", 32'(count4), 32'd4);
    cyc(0, 0, 32'h0, 0, 1, 0);
    check("s4_flush_top", pred_addr4, 32'h50);
    cyc(0, 1, 32'h0, 0, 0, 0);
    check("s4_pop_40", pred_addr4, 32'h40);
    cyc(0, 1, 32'h0, 1, 0, 0);
    check("s4_pop_30", pred_addr4, 32'h30);
    cyc(0, 1, 32'h0, 1, 0, 0);
    check("s4_pop_20_restored", pred_addr4, 32'h20);
    cyc(0, 1, 32'h0, 1, 0, 0);
    check("s4_empty", 32'(pred_valid4), 32'd0);
    cyc(0, 0, 32'h0, 1, 0, 0);

    // Checkpoint queue full; commit and push together keep it full
    do_reset();
    for (int i = 0; i < 7; i++) cyc(1, 0, 32'h1000 + 32'(i * 16), 0, 0, 0);
    check("s5_full_at7", 32'(full), 32'd0);
    cyc(1, 0, 32'h1070, 0, 0, 0);
    check("s5_full_at8", 32'(full), 32'd1);
    check("s5_count8", 32'(count), 32'd8);
    cyc(1, 0, 32'h2000, 1, 0, 0);
    check("s5_full_kept", 32'(full), 32'd1);
    check("s5_count9", 32'(count), 32'd9);
    check("s5_top", pred_addr, 32'h2000);
    cyc(0, 0, 32'h0, 0, 1, 0);
    check("s5_flush_count", 32'(count), 32'd1);
    check("s5_flush_top", pred_addr, 32'h1000);
    check("s5_flush_full", 32'(full), 32'd0);

    // Swap, stall, commit+flush from second checkpoint, async reset mid-sequence
    do_reset();
    cyc(1, 0, 32'h44, 0, 0, 0);
    cyc(0, 0, 32'h0, 1, 0, 0);
    cyc(1, 1, 32'h88, 0, 0, 0);
    check("s6_swap_top", pred_addr, 32'h88);
    check("s6_swap_count", 32'(count), 32'd1);
    cyc(1, 0, 32'h99, 0, 0, 0);
    check("s6_push99", pred_addr, 32'h99);
    cyc(1, 0, 32'h77, 0, 0, 1);
    check("s6_stall_count", 32'(count), 32'd2);
    check("s6_stall_top", pred_addr, 32'h99);
    cyc(0, 0, 32'h0, 1, 1, 0);
    check("s6_cf_count", 32'(count), 32'd1);
    check("s6_cf_top", pred_addr, 32'h88);
    cyc(1, 0, 32'h55, 0, 0, 0);
    check("s6_push55", 32'(count), 32'd2);
    #3;
    rst_ni = 1'b0;
    #1;
    check("s6_arst_valid", 32'(pred_valid), 32'd0);
    check("s6_arst_addr", pred_addr, 32'h0);
    check("s6_arst_count", 32'(count), 32'd0);
    check("s6_arst_full", 32'(full), 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    cyc(1, 0, 32'h66, 0, 0, 0);
    check("s6_post_count", 32'(count), 32'd1);
    check("s6_post_top", pred_addr, 32'h66);
    cyc(0, 0, 32'h0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
